snd_req_sched: RTL

Request-side scheduler for the sound manager (sndm). It collects one-cycle game sound events from the game FSM and queues them by priority. For each selected sound it drives sndm's snd_mode/trig pair and tracks sndm's playing output through the full handshake. It sits between the game controller and sndm, so the game logic never has to track sound timing or busy state.

---
 rtl/snd_req_sched_if.sv | 22 ++
 rtl/snd_req_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/snd_req_sched_if.sv
// Request/response bundle between the game controller, the scheduler and sndm.
// The slave side is the scheduler; the master side is its environment.
interface snd_req_sched_if;
    logic [6:0] evt;
    logic       mute;
    logic       playing;
    logic [2:0] snd_mode;
    logic       trig;
    logic       busy;
    logic [6:0] pending;
    logic       err;

    modport master (
        output evt, mute, playing,
        input  snd_mode, trig, busy, pending, err
    );

    modport slave (
        input  evt, mute, playing,
        output snd_mode, trig, busy, pending, err
    );
endinterface

// File: rtl/snd_req_sched.sv
// Purpose: priority-queues game sound events and runs the snd_mode/trig/playing handshake with sndm.
// Latency: evt pulse to trig high is 2 cycles when idle; TRIG_HOLD-cycle strobe, GAP_CYCLES between queued sounds.
// Backpressure: none upstream; events coalesce in the pending set while sndm is busy.
module snd_req_sched #(
    parameter int TRIG_HOLD     = 4,
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 20000,
    parameter int PREEMPT_MIN   = 6
) (
    input  logic            clk_1mhz,
    input  logic            rst,
    snd_req_sched_if.slave  sif
);
    localparam int MAX_A = (TRIG_HOLD > START_TIMEOUT) ? TRIG_HOLD : START_TIMEOUT;
    localparam int MAX_P = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {IDLE, ARM, WAIT_START, PLAYING, GAP} state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] gap_cnt;
    logic          seen;
    logic [6:0]    pend_q;
    logic [2:0]    mode_q;
    logic          trig_q;
    logic          busy_q;
    logic          err_q;

    logic [2:0]    sel;
    logic [6:0]    sel_bit;
    logic          preempt;
    logic          gap_done;
    logic          do_sel;
    logic [6:0]    clr_mask;

    // Highest set pending bit wins; sel is its 1-based code.
    always_comb begin
        sel     = '0;
        sel_bit = '0;
        for (int i = 0; i < 7; i++) begin
            if (pend_q[i]) begin
                sel        = 3'(i + 1);
                sel_bit    = '0;
                sel_bit[i] = 1'b1;
            end
        end
    end

    assign preempt  = (state == PLAYING) && (int'(sel) >= PREEMPT_MIN) && (sel > mode_q);
    assign gap_done = (state == GAP) && (gap_cnt == CW'(GAP_CYCLES));
    assign do_sel   = (sel != 3'd0) && ((state == IDLE) || gap_done || preempt);
    assign clr_mask = do_sel ? sel_bit : 7'd0;

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
            seen     <= 1'b0;
            pend_q   <= '0;
            mode_q   <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // A new event on the bit being cleared this cycle survives and replays.
            pend_q <= sif.mute ? 7'd0 : ((pend_q & ~clr_mask) | sif.evt);
            err_q  <= 1'b0;
            if (do_sel) begin
                mode_q   <= sel;
                trig_q   <= 1'b1;
                hold_cnt <= CW'(1);
                tmo_cnt  <= CW'(1);
                seen     <= 1'b0;
                busy_q   <= 1'b1;
                state    <= ARM;
            end else begin
                case (state)
                    IDLE: ;
                    ARM: begin
                        if (sif.playing) seen <= 1'b1;
                        tmo_cnt <= tmo_cnt + CW'(1);
                        if (hold_cnt == CW'(TRIG_HOLD)) begin
                            trig_q <= 1'b0;
                            state  <= WAIT_START;
                        end else begin
                            hold_cnt <= hold_cnt + CW'(1);
                        end
                    end
                    WAIT_START: begin
                        if (sif.playing || seen) begin
                            state <= PLAYING;
                        end else if (tmo_cnt == CW'(START_TIMEOUT)) begin
                            err_q  <= 1'b1;
                            mode_q <= '0;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            tmo_cnt <= tmo_cnt + CW'(1);
                        end
                    end
                    PLAYING: begin
                        if (!sif.playing) begin
                            mode_q <= '0;
                            if (pend_q != 7'd0) begin
                                gap_cnt <= CW'(1);
                                state   <= GAP;
                            end else begin
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    GAP: begin
                        // Reaching here with gap_done means the queue was muted away.
                        if (gap_done) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sif.snd_mode = mode_q;
    assign sif.trig     = trig_q;
    assign sif.busy     = busy_q;
    assign sif.pending  = pend_q;
    assign sif.err      = err_q;
endmodule
